// File: rtl/icache_param.sv
// Direct-mapped instruction cache with BLOCK_WORDS-word lines, zero-latency hits and word-by-word refill.
// Optional hit/miss statistics ports are enabled by defining ICACHE_STATS_EN.
module icache_param #(
   parameter int CACHE_BYTES = 128,
   parameter int BLOCK_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   output logic [31:0] RD,
   input  logic        RE,
   output logic        RDY,
   output logic [31:0] MAddr,
   input  logic [31:0] MData,
   output logic        MRead,
`ifdef ICACHE_STATS_EN
   output logic [31:0] HitCount,
   output logic [31:0] MissCount,
`endif
   input  logic        MRdy
);

   localparam int NUM_LINES = CACHE_BYTES / (4 * BLOCK_WORDS);
   localparam int OFF_W     = $clog2(BLOCK_WORDS);
   localparam int IDX_W     = $clog2(NUM_LINES);
   localparam int TAG_W     = 32 - IDX_W - OFF_W - 2;
   localparam int CTR_W     = (OFF_W > 0) ? OFF_W : 1;
   localparam logic [CTR_W-1:0] LAST_WORD = CTR_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

   state_t               state_q, state_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [CTR_W-1:0]     ctr_q, ctr_d;
   logic [TAG_W-1:0]     mtag_q, mtag_d;
   logic [IDX_W-1:0]     midx_q, midx_d;

   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [31:0]          data_q [NUM_LINES][BLOCK_WORDS];

   logic [TAG_W-1:0]     tag_a;
   logic [IDX_W-1:0]     idx_a;
   logic [CTR_W-1:0]     word_a;
   logic                 hit;
   logic                 data_we, tag_we, miss_start;
   logic                 unused_a;

   assign tag_a    = A[31:IDX_W+OFF_W+2];
   assign idx_a    = A[IDX_W+OFF_W+1:OFF_W+2];
   assign unused_a = ^A[1:0];

   // With single-word lines there are no offset bits; the word index is constant zero.
   generate
      if (OFF_W > 0) begin : g_off
         assign word_a = A[OFF_W+1:2];
         assign MAddr  = {mtag_q, midx_q, ctr_q, 2'b00};
      end else begin : g_no_off
         assign word_a = '0;
         assign MAddr  = {mtag_q, midx_q, 2'b00};
      end
   endgenerate

   assign hit = valid_q[idx_a] && (tag_q[idx_a] == tag_a);

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      ctr_d      = ctr_q;
      mtag_d     = mtag_q;
      midx_d     = midx_q;
      data_we    = 1'b0;
      tag_we     = 1'b0;
      miss_start = 1'b0;
      RDY        = 1'b0;
      MRead      = 1'b0;
      case (state_q)
         S_IDLE: begin
            RDY = RE && hit;
            // Invalidate up front so a partially refilled line can never hit.
            if (RE && !hit) begin
               miss_start     = 1'b1;
               mtag_d         = tag_a;
               midx_d         = idx_a;
               valid_d[idx_a] = 1'b0;
               ctr_d          = '0;
               state_d        = S_REQ;
            end
         end
         S_REQ: begin
            MRead = 1'b1;
            if (MRdy) begin
               data_we = 1'b1;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (ctr_q == LAST_WORD) begin
               valid_d[midx_q] = 1'b1;
               tag_we          = 1'b1;
               ctr_d           = '0;
               state_d         = S_IDLE;
            end else begin
               ctr_d   = ctr_q + CTR_W'(1);
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
      RD = RDY ? data_q[idx_a][word_a] : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         valid_q <= '0;
         ctr_q   <= '0;
         mtag_q  <= '0;
         midx_q  <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         ctr_q   <= ctr_d;
         mtag_q  <= mtag_d;
         midx_q  <= midx_d;
      end
   end

   // Tag and data storage carry no reset; valid bits alone gate hits.
   always_ff @(posedge clk) begin
      if (data_we) data_q[midx_q][ctr_q] <= MData;
      if (tag_we)  tag_q[midx_q]         <= mtag_q;
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (RDY && hit_cnt_q != 32'hFFFF_FFFF)         hit_cnt_d  = hit_cnt_q + 32'd1;
      if (miss_start && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign HitCount  = hit_cnt_q;
   assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_param.sv
// Directed self-checking bench for icache_param (128 bytes, 4-word lines) with a 9-cycle memory model.
module tb_icache_param;
   localparam int D = 8;          // model raises MRdy after D cycles of MRead, so REQ lasts D+1 cycles
   localparam int MISS_LAT = 41;  // 4*(9+1)+1

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] A = '0;
   logic        RE = 1'b0;
   logic [31:0] RD;
   logic        RDY;
   logic [31:0] MAddr;
   logic [31:0] MData = '0;
   logic        MRead;
   logic        MRdy = 1'b0;
`ifdef ICACHE_STATS_EN
   logic [31:0] HitCount, MissCount;
`endif

   int errors = 0;
   int checks = 0;
   int cnt = 0;
   logic [31:0] addr_q[$];

   icache_param #(.CACHE_BYTES(128), .BLOCK_WORDS(4)) dut (
      .clk(clk), .reset(reset), .A(A), .RD(RD), .RE(RE), .RDY(RDY),
      .MAddr(MAddr), .MData(MData), .MRead(MRead),
`ifdef ICACHE_STATS_EN
      .HitCount(HitCount), .MissCount(MissCount),
`endif
      .MRdy(MRdy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] widx);
      return 32'hA500_0000 + (widx << 8) + widx;
   endfunction

   // Memory model: one-cycle MRdy pulse after D cycles of MRead; logs each served address.
   always @(posedge clk) begin
      if (MRead && !MRdy) begin
         if (cnt == D - 1) begin
            MRdy  <= 1'b1;
            MData <= mem_word(MAddr >> 2);
            addr_q.push_back(MAddr);
            cnt   <= 0;
         end else begin
            cnt <= cnt + 1;
         end
      end else begin
         MRdy <= 1'b0;
         cnt  <= 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From the negedge of a miss-detect cycle, wait for RDY; n is cycles elapsed.
   task automatic wait_rdy(output int n);
      n = 0;
      while (!RDY && n < 300) begin
         step();
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      @(negedge clk);
      checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", RDY); end
      checks++; if (MRead !== 1'b0) begin errors++; $display("FAIL reset_mread: got %b expected 0", MRead); end
      checks++; if (MAddr !== 32'h0) begin errors++; $display("FAIL reset_maddr: got %h expected 0", MAddr); end
      checks++; if (RD !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h expected 0", RD); end
      step();
      reset = 1'b0;
      $display("reset: RDY=%b MRead=%b MAddr=%h RD=%h", RDY, MRead, MAddr, RD);
   endtask

   task automatic test_cold_miss();
      int n;
      A = 32'h10; RE = 1'b1; addr_q.delete();
      @(negedge clk);
      checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL cold_detect_rdy: got %b expected 0", RDY); end
      wait_rdy(n);
      checks++; if (n != MISS_LAT) begin errors++; $display("FAIL cold_latency: got %0d expected %0d", n, MISS_LAT); end
      checks++; if (RD !== mem_word(4)) begin errors++; $display("FAIL cold_rd: got %h expected %h", RD, mem_word(4)); end
      checks++; if (MRead !== 1'b0) begin errors++; $display("FAIL cold_mread: got %b expected 0", MRead); end
      checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL cold_nreq: got %0d expected 4", addr_q.size()); end
      for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
         checks++;
         if (addr_q[i] !== 32'h10 + 4*i) begin errors++; $display("FAIL cold_maddr%0d: got %h expected %h", i, addr_q[i], 32'h10 + 4*i); end
      end
      $display("cold miss A=10: latency=%0d RD=%h", n, RD);
      step();
   endtask

   task automatic test_spatial_hits();
      for (int k = 1; k <= 3; k++) begin
         A = 32'h10 + 4*k; RE = 1'b1;
         @(negedge clk);
         checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL spatial_rdy%0d: got %b expected 1", k, RDY); end
         checks++; if (RD !== mem_word(4 + k)) begin errors++; $display("FAIL spatial_rd%0d: got %h expected %h", k, RD, mem_word(4 + k)); end
         checks++; if (MRead !== 1'b0) begin errors++; $display("FAIL spatial_mread%0d: got %b expected 0", k, MRead); end
         $display("hit A=%h: RDY=%b RD=%h", A, RDY, RD);
         step();
      end
      RE = 1'b0;
      @(negedge clk);
`ifdef ICACHE_STATS_EN
      checks++; if (MissCount !== 32'd1) begin errors++; $display("FAIL stats_miss: got %0d expected 1", MissCount); end
      checks++; if (HitCount !== 32'd4) begin errors++; $display("FAIL stats_hit: got %0d expected 4", HitCount); end
      $display("stats: HitCount=%0d MissCount=%0d", HitCount, MissCount);
`endif
      step();
   endtask

   task automatic test_conflict();
      int n;
      A = 32'h10; RE = 1'b1;
      @(negedge clk);
      checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL conflict_prehit: got %b expected 1", RDY); end
      step();
      A = 32'h90; addr_q.delete();
      @(negedge clk);
      checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL conflict_miss_rdy: got %b expected 0", RDY); end
      wait_rdy(n);
      checks++; if (n != MISS_LAT) begin errors++; $display("FAIL conflict_latency: got %0d expected %0d", n, MISS_LAT); end
      checks++; if (RD !== mem_word(36)) begin errors++; $display("FAIL conflict_rd: got %h expected %h", RD, mem_word(36)); end
      checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL conflict_nreq: got %0d expected 4", addr_q.size()); end
      for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
         checks++;
         if (addr_q[i] !== 32'h90 + 4*i) begin errors++; $display("FAIL conflict_maddr%0d: got %h expected %h", i, addr_q[i], 32'h90 + 4*i); end
      end
      $display("conflict A=90: latency=%0d RD=%h", n, RD);
      step();
      A = 32'h10; addr_q.delete();
      @(negedge clk);
      checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL conflict_evicted_rdy: got %b expected 0", RDY); end
      wait_rdy(n);
      checks++; if (RD !== mem_word(4)) begin errors++; $display("FAIL conflict_refill_rd: got %h expected %h", RD, mem_word(4)); end
      checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL conflict_refill_nreq: got %0d expected 4", addr_q.size()); end
      $display("refetch A=10: latency=%0d RD=%h", n, RD);
      step();
   endtask

   task automatic test_hold();
      int guard;
      A = 32'h40; RE = 1'b1; addr_q.delete();
      @(negedge clk);
      checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL hold_miss_rdy: got %b expected 0", RDY); end
      step();
      A = 32'h0; RE = 1'b0;
      guard = 0;
      while (addr_q.size() < 4 && guard < 300) begin step(); guard++; end
      checks++; if (guard >= 300) begin errors++; $display("FAIL hold_timeout: got %0d requests expected 4", addr_q.size()); end
      step(); step(); step();
      for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
         checks++;
         if (addr_q[i] !== 32'h40 + 4*i) begin errors++; $display("FAIL hold_maddr%0d: got %h expected %h", i, addr_q[i], 32'h40 + 4*i); end
      end
      A = 32'h44; RE = 1'b1;
      @(negedge clk);
      checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL hold_hit_rdy: got %b expected 1", RDY); end
      checks++; if (RD !== mem_word(17)) begin errors++; $display("FAIL hold_hit_rd: got %h expected %h", RD, mem_word(17)); end
      $display("hold refill 40: requests=%0d then A=44 RDY=%b RD=%h", addr_q.size(), RDY, RD);
      step();
   endtask

   task automatic test_reset_mid_refill();
      int guard;
      int n;
      A = 32'h20; RE = 1'b1; addr_q.delete();
      guard = 0;
      while (!(MRead === 1'b1 && MAddr === 32'h28) && guard < 300) begin step(); guard++; end
      checks++; if (guard >= 300) begin errors++; $display("FAIL midrst_reach_word2: got MAddr %h expected 00000028", MAddr); end
      reset = 1'b1;
      #1;
      checks++; if (MRead !== 1'b0) begin errors++; $display("FAIL midrst_mread: got %b expected 0", MRead); end
      checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL midrst_rdy: got %b expected 0", RDY); end
      step();
      step();
      reset = 1'b0; addr_q.delete();
      @(negedge clk);
      checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL midrst_remiss_rdy: got %b expected 0", RDY); end
      wait_rdy(n);
      checks++; if (n != MISS_LAT) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", n, MISS_LAT); end
      checks++; if (RD !== mem_word(8)) begin errors++; $display("FAIL midrst_rd: got %h expected %h", RD, mem_word(8)); end
      $display("reset mid-refill A=20: refetch latency=%0d RD=%h", n, RD);
      step();
      RE = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_spatial_hits();
      test_conflict();
      test_hold();
      test_reset_mid_refill();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
